// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory port arbiter.
package mem_arb_pkg;

    // Access sequencer states: arbitrate, drive memory, acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Which requester owns the access currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int DEF_SIZE     = 256;
    localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch
// (IF) and data load/store (DM). Data side has priority; fetch is forced to
// win after MAX_WAIT consecutive lost arbitrations. Every access takes three
// cycles: IDLE (arbitrate) -> SERVE (memory access) -> RESP (ack pulse).
//
// Handshake: a requester raises req with its address/data stable and holds
// them until it sees a one-cycle ack; rdata/err are valid with ack and hold
// until that port's next completion. Req still high in the cycle after ack
// starts a new transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SIZE     = DEF_SIZE,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  wait_cnt;

    logic              any_req;
    logic              starved;
    logic              grant_dm;
    logic [ADDR_W-1:0] sel_addr;
    logic              in_range;

    // Arbitration: data wins unless fetch has waited MAX_WAIT times in a row.
    always_comb begin
        any_req  = if_req | dm_req;
        starved  = (wait_cnt == CNT_W'(MAX_WAIT));
        grant_dm = dm_req & ~(if_req & starved);
    end

    // Memory drive: only the SERVE state touches the memory, so a reset
    // (which forces IDLE asynchronously) removes mem_we immediately.
    always_comb begin
        sel_addr = (owner == OWN_DM) ? dm_addr : if_addr;
        in_range = (sel_addr < ADDR_W'(SIZE));
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        if (state == SERVE) begin
            mem_addr = sel_addr;
            if (owner == OWN_DM) begin
                mem_din = dm_wdata;
                mem_we  = in_range & dm_we;
                mem_re  = in_range & ~dm_we;
            end else begin
                mem_re  = in_range;
            end
        end
    end

    assign busy = (state != IDLE);

    // Access sequencer with starvation counter and registered ack/rdata/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            wait_cnt <= '0;
            if_ack   <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            dm_ack   <= 1'b0;
            dm_rdata <= '0;
            dm_err   <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // Fetch idle or granted resets its wait history; a loss
                    // while both request counts towards the forced grant.
                    if (!if_req || !grant_dm) begin
                        wait_cnt <= '0;
                    end else if (!starved) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (any_req) begin
                        owner <= grant_dm ? OWN_DM : OWN_IF;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (owner == OWN_DM) begin
                        dm_rdata <= (in_range && !dm_we) ? mem_dout : '0;
                        dm_err   <= ~in_range;
                        dm_ack   <= 1'b1;
                    end else begin
                        if_rdata <= in_range ? mem_dout : '0;
                        if_err   <= ~in_range;
                        if_ack   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model
// (grant time, fixed 3-cycle occupancy, reference memory) checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SZ = 256;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          dm_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_dout;
    logic          busy;

    mem_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .SIZE(SZ), .MAX_WAIT(MW), .CNT_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .dm_err(dm_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_re(mem_re), .mem_dout(mem_dout), .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    // ---------------- memory attached to the DUT ----------------
    logic [DW-1:0] mem     [0:SZ-1];
    logic [DW-1:0] ref_mem [0:SZ-1];

    assign mem_dout = (mem_re && mem_addr < AW'(SZ)) ? mem[mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < AW'(SZ)) mem[mem_addr[7:0]] <= mem_din;
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // The arbiter is free at cycle free_at; a grant at cycle g occupies the
    // memory in g+1 and acknowledges in g+2, after which it is free again.
    int            cyc;
    int            free_at, serve_at, ack_at;
    int            losses;
    logic          m_dm, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] p_rdata, e_if_rdata, e_dm_rdata;
    logic          p_err, e_if_err, e_dm_err;
    logic          in_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; free_at = 0; serve_at = -1; ack_at = -1; losses = 0;
            m_dm = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            p_rdata = '0; p_err = 1'b0;
            e_if_rdata = '0; e_dm_rdata = '0; e_if_err = 1'b0; e_dm_err = 1'b0;
        end else begin
            if (cyc == ack_at) begin
                if (m_dm) begin e_dm_rdata = p_rdata; e_dm_err = p_err; end
                else      begin e_if_rdata = p_rdata; e_if_err = p_err; end
            end
            chk("m_if_ack",   if_ack,   (cyc == ack_at) && !m_dm);
            chk("m_dm_ack",   dm_ack,   (cyc == ack_at) && m_dm);
            chk("m_if_rdata", if_rdata, e_if_rdata);
            chk("m_if_err",   if_err,   e_if_err);
            chk("m_dm_rdata", dm_rdata, e_dm_rdata);
            chk("m_dm_err",   dm_err,   e_dm_err);
            chk("m_busy",     busy,     cyc < free_at);
            if (cyc == serve_at) begin
                in_r = (m_addr < AW'(SZ));
                chk("m_mem_addr", mem_addr, m_addr);
                chk("m_mem_re",   mem_re,   in_r && !(m_dm && m_we));
                chk("m_mem_we",   mem_we,   in_r && m_dm && m_we);
                if (m_dm) chk("m_mem_din", mem_din, m_wdata);
                if (m_dm && m_we) begin
                    if (in_r) ref_mem[m_addr[7:0]] = m_wdata;
                    p_rdata = '0;
                end else begin
                    p_rdata = in_r ? ref_mem[m_addr[7:0]] : '0;
                end
                p_err = !in_r;
            end
            if (cyc >= free_at) begin
                chk("m_idle_we", mem_we, 1'b0);
                chk("m_idle_re", mem_re, 1'b0);
                if (if_req || dm_req) begin
                    if (if_req && dm_req) begin
                        m_dm = (losses != MW);
                        losses = m_dm ? ((losses < MW) ? losses + 1 : MW) : 0;
                    end else begin
                        m_dm = dm_req;
                        losses = 0;
                    end
                    m_we     = m_dm ? dm_we : 1'b0;
                    m_addr   = m_dm ? dm_addr : if_addr;
                    m_wdata  = dm_wdata;
                    serve_at = cyc + 1;
                    ack_at   = cyc + 2;
                    free_at  = cyc + 3;
                end else begin
                    losses = 0;
                end
            end
            cyc++;
        end
    end

    // Sticky watch for any memory strobe during an out-of-range access.
    logic oor_watch = 1'b0;
    logic oor_seen  = 1'b0;
    always @(negedge clk) if (oor_watch && (mem_re || mem_we)) oor_seen = 1'b1;

    // ---------------- driver helpers ----------------
    task automatic wait_ack(input bit dm, output int at);
        logic found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dm ? dm_ack : if_ack) begin found = 1'b1; at = tcyc; break; end
        end
        chk(dm ? "dm_ack_arrives" : "if_ack_arrives", found, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {if_ack, if_err, dm_ack, dm_err, mem_we, mem_re, busy}, 7'd0);
        chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
        chk({tag, "_mem"}, {mem_addr, mem_din}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    int t0, ta, tb, n_dm;
    logic seen;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < SZ; i++) mem[i] = 32'hC000_0000 | i;
        mem[0] = 32'h0030_2083;
        mem[3] = 32'd17;
        mem[9] = 32'h99;
        for (int i = 0; i < SZ; i++) ref_mem[i] = mem[i];

        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Reset in the middle of a store's SERVE cycle.
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9; dm_wdata = 32'hAA;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_we) begin seen = 1'b1; break; end
        end
        chk("rst_store_reaches_serve", seen, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we_drop", mem_we, 1'b0);
        chk_all_zero("rst_mid");
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        step();
        chk("rst_mem9_kept", mem[9], 32'h99);
        rst_n = 1'b1;

        // Isolated fetch: ack two cycles after the request.
        step();
        if_req = 1'b1; if_addr = 0; t0 = tcyc;
        wait_ack(1'b0, ta);
        chk("fetch_latency", ta - t0, 2);
        chk("fetch_rdata", if_rdata, 32'h0030_2083);
        chk("fetch_err", if_err, 1'b0);
        step(); if_req = 1'b0;

        // Simultaneous requests: data first, fetch three cycles later.
        step();
        if_req = 1'b1; if_addr = 1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 3;
        wait_ack(1'b1, ta);
        chk("sim_dm_rdata", dm_rdata, 32'd17);
        chk("sim_if_not_yet", if_ack, 1'b0);
        step(); dm_req = 1'b0;
        wait_ack(1'b0, tb);
        chk("sim_if_gap", tb - ta, 3);
        chk("sim_if_rdata", if_rdata, 32'hC000_0001);
        step(); if_req = 1'b0;

        // Store then back-to-back load of the same address.
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9; dm_wdata = 32'h11;
        wait_ack(1'b1, ta);
        chk("store_rdata_zero", dm_rdata, 32'd0);
        chk("store_err", dm_err, 1'b0);
        step(); dm_we = 1'b0;
        wait_ack(1'b1, tb);
        chk("load_after_store", dm_rdata, 32'h11);
        chk("load_back_to_back", tb - ta, 3);
        step(); dm_req = 1'b0;

        // Starvation guard: four data grants, then fetch; then again.
        step();
        if_req = 1'b1; if_addr = 2; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 4;
        for (int round = 0; round < 2; round++) begin
            n_dm = 0; seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (dm_ack) n_dm++;
                if (if_ack) begin seen = 1'b1; break; end
            end
            chk(round == 0 ? "starve_if_granted" : "starve_if_again", seen, 1'b1);
            chk(round == 0 ? "starve_dm_grants" : "starve_dm_after_clear", n_dm, 4);
        end
        chk("starve_if_rdata", if_rdata, 32'hC000_0002);
        step(); if_req = 1'b0; dm_req = 1'b0;

        // Out-of-range load and fetch.
        step();
        oor_watch = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 300;
        wait_ack(1'b1, ta);
        chk("oor_dm_err", dm_err, 1'b1);
        chk("oor_dm_rdata", dm_rdata, 32'd0);
        step(); dm_req = 1'b0;
        if_req = 1'b1; if_addr = 256;
        wait_ack(1'b0, tb);
        chk("oor_if_err", if_err, 1'b1);
        chk("oor_if_rdata", if_rdata, 32'd0);
        step(); if_req = 1'b0;
        oor_watch = 1'b0;
        chk("oor_no_mem_strobe", oor_seen, 1'b0);

        repeat (4) step();
        chk("final_mem9", mem[9], 32'h11);
        chk("final_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
